// File: rtl/mips_pkg.sv
// Shared definitions for the five-stage MIPS pipeline: ALU operation codes,
// well-known register numbers and the ID/EX pipeline register layout.
package mips_pkg;

   // ALU operation codes carried on aluc
   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0100;
   localparam logic [3:0] ALU_AND = 4'b0001;
   localparam logic [3:0] ALU_OR  = 4'b0101;
   localparam logic [3:0] ALU_XOR = 4'b0010;
   localparam logic [3:0] ALU_LUI = 4'b0110;
   localparam logic [3:0] ALU_SLL = 4'b0011;
   localparam logic [3:0] ALU_SRL = 4'b0111;
   localparam logic [3:0] ALU_SRA = 4'b1111;

   // Architectural register numbers with special meaning
   localparam logic [4:0] REG_ZERO = 5'd0;
   localparam logic [4:0] REG_RA   = 5'd31;

   // Contents of the ID/EX pipeline register. An all-zero value is a bubble.
   typedef struct packed {
      logic        valid;
      logic        wreg;
      logic        m2reg;
      logic        wmem;
      logic        jal;
      logic [4:0]  rn;
      logic [3:0]  aluc;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] st;
      logic [31:0] pc4;
   } ex_reg_t;

   // True when a stage will write a register that can actually be observed;
   // writes to $0 are discarded by the register file so they never forward.
   function automatic logic live_dest(input logic wreg, input logic [4:0] rn);
      return wreg && (rn != REG_ZERO);
   endfunction

   // True when a stage's destination matches a used, non-zero source.
   function automatic logic dest_hits(input logic wreg, input logic [4:0] rn,
                                      input logic used, input logic [4:0] src);
      return used && live_dest(wreg, rn) && (rn == src);
   endfunction

endpackage

// File: rtl/fwd_unit.sv
// Per-operand forwarding mux. Picks the freshest copy of one source register:
// the result being computed in EX, then the value leaving MEM, and finally
// the register-file read data.
module fwd_unit
   import mips_pkg::*;
(
   input  logic        use_i,        // operand is a real source this cycle
   input  logic [4:0]  src_i,        // source register number
   input  logic [31:0] rf_data_i,    // register-file read data
   input  logic        ex_valid_i,
   input  logic        ex_wreg_i,
   input  logic        ex_m2reg_i,
   input  logic [4:0]  ex_rn_i,
   input  logic [31:0] ex_alu_i,     // combinational ALU result in EX
   input  logic        mem_wreg_i,
   input  logic        mem_m2reg_i,
   input  logic [4:0]  mem_rn_i,
   input  logic [31:0] mem_alu_i,
   input  logic [31:0] mem_data_i,
   output logic [31:0] data_o
);

   logic ex_hit;
   logic mem_hit;

   // A load in EX has no data yet, so it is skipped here; the hazard logic
   // bubbles the consumer and the retry picks the value up from MEM.
   always_comb begin
      ex_hit  = ex_valid_i && !ex_m2reg_i && dest_hits(ex_wreg_i, ex_rn_i, use_i, src_i);
      mem_hit = dest_hits(mem_wreg_i, mem_rn_i, use_i, src_i);
   end

   // Priority select: EX beats MEM beats the register file
   always_comb begin
      data_o = rf_data_i;
      if (ex_hit) begin
         data_o = ex_alu_i;
      end else if (mem_hit) begin
         data_o = mem_m2reg_i ? mem_data_i : mem_alu_i;
      end
   end

endmodule

// File: rtl/id_exe_stage.sv
// ID/EX stage: resolves operand forwarding, detects load-use hazards,
// registers ALU operands and control into EX, inserts bubbles on hazards and
// flushes, and keeps a saturating bubble counter for performance debug.
//
// Handshake: stall is a combinational request to the front end to hold PC
// and IF/ID for this cycle; it is raised only when the ID instruction must be
// retried (load-use), never for a flush, since a flushed instruction is dead.
module id_exe_stage
   import mips_pkg::*;
#(
   parameter int BCNT_W = 16
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              d_valid,
   input  logic [4:0]        d_rs,
   input  logic [4:0]        d_rt,
   input  logic [4:0]        d_rn,
   input  logic [31:0]       d_qa,
   input  logic [31:0]       d_qb,
   input  logic [31:0]       d_imm,
   input  logic [3:0]        d_aluc,
   input  logic              d_aluimm,
   input  logic              d_shift,
   input  logic              d_wreg,
   input  logic              d_m2reg,
   input  logic              d_wmem,
   input  logic              d_jal,
   input  logic              d_usert,
   input  logic [31:0]       d_pc4,
   input  logic [31:0]       e_alu_s,
   input  logic              m_wreg,
   input  logic              m_m2reg,
   input  logic [4:0]        m_rn,
   input  logic [31:0]       m_alu,
   input  logic [31:0]       m_mem,
   input  logic              flush,
   output logic              stall,
   output logic [31:0]       e_a,
   output logic [31:0]       e_b,
   output logic [3:0]        e_aluc,
   output logic              e_wreg,
   output logic              e_m2reg,
   output logic              e_wmem,
   output logic              e_jal,
   output logic              e_valid,
   output logic [4:0]        e_rn,
   output logic [31:0]       e_pc4,
   output logic [31:0]       e_st,
   output logic [BCNT_W-1:0] bubble_cnt
);

   ex_reg_t           ex_q;
   ex_reg_t           ex_d;
   logic [BCNT_W-1:0] bcnt_q;
   logic [BCNT_W-1:0] bcnt_d;
   logic [31:0]       fwd_rs;
   logic [31:0]       fwd_rt;
   logic              load_in_ex;
   logic              hazard;
   logic              bubble;
   logic              bump;

   // Source operand rs is always a real source
   fwd_unit u_fwd_rs (
      .use_i       (1'b1),
      .src_i       (d_rs),
      .rf_data_i   (d_qa),
      .ex_valid_i  (ex_q.valid),
      .ex_wreg_i   (ex_q.wreg),
      .ex_m2reg_i  (ex_q.m2reg),
      .ex_rn_i     (ex_q.rn),
      .ex_alu_i    (e_alu_s),
      .mem_wreg_i  (m_wreg),
      .mem_m2reg_i (m_m2reg),
      .mem_rn_i    (m_rn),
      .mem_alu_i   (m_alu),
      .mem_data_i  (m_mem),
      .data_o      (fwd_rs)
   );

   // Source operand rt only forwards for R-type and store instructions
   fwd_unit u_fwd_rt (
      .use_i       (d_usert),
      .src_i       (d_rt),
      .rf_data_i   (d_qb),
      .ex_valid_i  (ex_q.valid),
      .ex_wreg_i   (ex_q.wreg),
      .ex_m2reg_i  (ex_q.m2reg),
      .ex_rn_i     (ex_q.rn),
      .ex_alu_i    (e_alu_s),
      .mem_wreg_i  (m_wreg),
      .mem_m2reg_i (m_m2reg),
      .mem_rn_i    (m_rn),
      .mem_alu_i   (m_alu),
      .mem_data_i  (m_mem),
      .data_o      (fwd_rt)
   );

   // Load-use detection against the instruction currently held in EX
   always_comb begin
      load_in_ex = ex_q.valid && ex_q.m2reg && live_dest(ex_q.wreg, ex_q.rn);
      hazard     = d_valid && load_in_ex &&
                   ((ex_q.rn == d_rs) || (d_usert && (ex_q.rn == d_rt)));
   end

   // A flush kills the ID instruction, so there is nothing left to retry
   assign stall  = hazard && !flush;
   assign bubble = flush || hazard || !d_valid;
   assign bump   = d_valid && (hazard || flush);

   // Next EX register contents: a captured instruction or an all-zero bubble
   always_comb begin
      ex_d = '0;
      if (!bubble) begin
         ex_d.valid = 1'b1;
         ex_d.wreg  = d_wreg;
         ex_d.m2reg = d_m2reg;
         ex_d.wmem  = d_wmem;
         ex_d.jal   = d_jal;
         ex_d.rn    = d_rn;
         ex_d.aluc  = d_aluc;
         ex_d.a     = d_shift ? {27'b0, d_imm[10:6]} : fwd_rs;
         ex_d.b     = d_aluimm ? d_imm : fwd_rt;
         ex_d.st    = fwd_rt;
         ex_d.pc4   = d_pc4;
      end
   end

   // Bubble counter sticks at all ones instead of wrapping
   always_comb begin
      bcnt_d = bcnt_q;
      if (bump && (bcnt_q != '1)) begin
         bcnt_d = bcnt_q + BCNT_W'(1);
      end
   end

   // EX pipeline register and bubble counter
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         ex_q   <= '0;
         bcnt_q <= '0;
      end else begin
         ex_q   <= ex_d;
         bcnt_q <= bcnt_d;
      end
   end

   assign e_valid    = ex_q.valid;
   assign e_wreg     = ex_q.wreg;
   assign e_m2reg    = ex_q.m2reg;
   assign e_wmem     = ex_q.wmem;
   assign e_jal      = ex_q.jal;
   assign e_rn       = ex_q.rn;
   assign e_aluc     = ex_q.aluc;
   assign e_a        = ex_q.a;
   assign e_b        = ex_q.b;
   assign e_st       = ex_q.st;
   assign e_pc4      = ex_q.pc4;
   assign bubble_cnt = bcnt_q;

endmodule

// File: tb/tb_id_exe_stage.sv
// Self-checking bench for id_exe_stage: directed pipeline scenarios followed
// by randomized traffic, compared against a behavioural model of the stage.
module tb_id_exe_stage;
   import mips_pkg::*;

   localparam int BCNT_W = 16;
   localparam int unsigned CNT_MAX = (1 << BCNT_W) - 1;

   logic              clock = 1'b0;
   logic              resetn = 1'b0;
   logic              d_valid, d_aluimm, d_shift, d_wreg, d_m2reg, d_wmem, d_jal, d_usert;
   logic [4:0]        d_rs, d_rt, d_rn, m_rn;
   logic [31:0]       d_qa, d_qb, d_imm, d_pc4, e_alu_s, m_alu, m_mem;
   logic [3:0]        d_aluc;
   logic              m_wreg, m_m2reg, flush;
   logic              stall;
   logic [31:0]       e_a, e_b, e_pc4, e_st;
   logic [3:0]        e_aluc;
   logic              e_wreg, e_m2reg, e_wmem, e_jal, e_valid;
   logic [4:0]        e_rn;
   logic [BCNT_W-1:0] bubble_cnt;

   // Model view of what EX should hold
   typedef struct packed {
      logic        valid, wreg, m2reg, wmem, jal;
      logic [4:0]  rn;
      logic [3:0]  aluc;
      logic [31:0] a, b, st, pc4;
   } ex_t;

   ex_t              mdl;
   int unsigned      mdl_cnt;
   logic [$bits(ex_t)-1:0] exp_q[$];
   int               n_checks = 0;
   int               n_errors = 0;

   id_exe_stage #(.BCNT_W(BCNT_W)) dut (
      .clock(clock), .resetn(resetn), .d_valid(d_valid),
      .d_rs(d_rs), .d_rt(d_rt), .d_rn(d_rn), .d_qa(d_qa), .d_qb(d_qb),
      .d_imm(d_imm), .d_aluc(d_aluc), .d_aluimm(d_aluimm), .d_shift(d_shift),
      .d_wreg(d_wreg), .d_m2reg(d_m2reg), .d_wmem(d_wmem), .d_jal(d_jal),
      .d_usert(d_usert), .d_pc4(d_pc4), .e_alu_s(e_alu_s),
      .m_wreg(m_wreg), .m_m2reg(m_m2reg), .m_rn(m_rn), .m_alu(m_alu), .m_mem(m_mem),
      .flush(flush), .stall(stall), .e_a(e_a), .e_b(e_b), .e_aluc(e_aluc),
      .e_wreg(e_wreg), .e_m2reg(e_m2reg), .e_wmem(e_wmem), .e_jal(e_jal),
      .e_valid(e_valid), .e_rn(e_rn), .e_pc4(e_pc4), .e_st(e_st),
      .bubble_cnt(bubble_cnt)
   );

   // Clock
   always #5 clock = ~clock;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // Value a source register holds from the consumer's point of view
   function automatic logic [31:0] model_src(input logic [4:0] r, input logic used,
                                             input logic [31:0] rf);
      if (!used || r == 5'd0) return rf;
      if (mdl.valid && mdl.wreg && !mdl.m2reg && mdl.rn == r) return e_alu_s;
      if (m_wreg && m_rn == r) return m_m2reg ? m_mem : m_alu;
      return rf;
   endfunction

   function automatic logic model_hazard();
      logic load_pending;
      load_pending = mdl.valid && mdl.wreg && mdl.m2reg && mdl.rn != 5'd0;
      return d_valid && load_pending &&
             (mdl.rn == d_rs || (d_usert && mdl.rn == d_rt));
   endfunction

   function automatic ex_t model_next(input logic hz);
      ex_t n;
      logic [31:0] vs, vt;
      n = '0;
      if (flush || hz || !d_valid) return n;
      vs = model_src(d_rs, 1'b1, d_qa);
      vt = model_src(d_rt, d_usert, d_qb);
      n.valid = 1'b1;   n.wreg = d_wreg;   n.m2reg = d_m2reg;
      n.wmem  = d_wmem; n.jal  = d_jal;    n.rn    = d_rn;
      n.aluc  = d_aluc; n.pc4  = d_pc4;    n.st    = vt;
      n.a     = d_shift ? 32'(d_imm[10:6]) : vs;
      n.b     = d_aluimm ? d_imm : vt;
      return n;
   endfunction

   task automatic compare_outputs();
      check_val("e_valid", 32'(e_valid), 32'(mdl.valid));
      check_val("e_wreg",  32'(e_wreg),  32'(mdl.wreg));
      check_val("e_m2reg", 32'(e_m2reg), 32'(mdl.m2reg));
      check_val("e_wmem",  32'(e_wmem),  32'(mdl.wmem));
      check_val("e_jal",   32'(e_jal),   32'(mdl.jal));
      check_val("e_rn",    32'(e_rn),    32'(mdl.rn));
      check_val("e_aluc",  32'(e_aluc),  32'(mdl.aluc));
      check_val("e_a",     e_a,          mdl.a);
      check_val("e_b",     e_b,          mdl.b);
      check_val("e_st",    e_st,         mdl.st);
      check_val("e_pc4",   e_pc4,        mdl.pc4);
      check_val("bubble_cnt", 32'(bubble_cnt), mdl_cnt);
   endtask

   // One pipeline cycle: check stall, predict EX, clock, compare
   task automatic step();
      logic hz;
      #1;
      hz = model_hazard();
      check_val("stall", 32'(stall), 32'(hz && !flush));
      exp_q.push_back(model_next(hz));
      if (d_valid && (hz || flush) && mdl_cnt < CNT_MAX) mdl_cnt++;
      @(posedge clock);
      #1;
      mdl = exp_q.pop_front();
      compare_outputs();
   endtask

   task automatic idle_inputs();
      d_valid = 0; d_rs = 0; d_rt = 0; d_rn = 0; d_qa = 0; d_qb = 0; d_imm = 0;
      d_aluc = ALU_ADD; d_aluimm = 0; d_shift = 0; d_wreg = 0; d_m2reg = 0;
      d_wmem = 0; d_jal = 0; d_usert = 0; d_pc4 = 0; e_alu_s = 0;
      m_wreg = 0; m_m2reg = 0; m_rn = 0; m_alu = 0; m_mem = 0; flush = 0;
   endtask

   // Plain instruction in ID: rs/rt read, rn written, R-type unless noted
   task automatic instr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rn,
                        input logic [3:0] aluc, input logic usert, input logic m2reg);
      d_valid = 1; d_rs = rs; d_rt = rt; d_rn = rn; d_aluc = aluc;
      d_usert = usert; d_m2reg = m2reg; d_wreg = 1; d_aluimm = m2reg;
      d_shift = 0; d_wmem = 0; d_jal = 0; d_pc4 = d_pc4 + 32'd4;
      d_qa = $urandom; d_qb = $urandom; d_imm = $urandom_range(255, 0);
   endtask

   task automatic rand_inputs();
      d_valid = $urandom_range(9, 0) != 0;
      d_rs = 5'($urandom_range(3, 0)); d_rt = 5'($urandom_range(3, 0));
      d_rn = 5'($urandom_range(3, 0)); m_rn = 5'($urandom_range(3, 0));
      d_qa = $urandom; d_qb = $urandom; d_imm = $urandom; d_pc4 = $urandom;
      d_aluc = 4'($urandom_range(15, 0));
      d_aluimm = 1'($urandom_range(1, 0)); d_shift = 1'($urandom_range(1, 0));
      d_wreg = 1'($urandom_range(1, 0));   d_m2reg = 1'($urandom_range(1, 0));
      d_wmem = 1'($urandom_range(1, 0));   d_jal = 1'($urandom_range(1, 0));
      d_usert = 1'($urandom_range(1, 0));  e_alu_s = $urandom;
      m_wreg = 1'($urandom_range(1, 0));   m_m2reg = 1'($urandom_range(1, 0));
      m_alu = $urandom; m_mem = $urandom;
      flush = $urandom_range(7, 0) == 0;
   endtask

   task automatic do_reset();
      resetn = 0;
      mdl = '0;
      mdl_cnt = 0;
      repeat (2) @(posedge clock);
      #1 resetn = 1;
   endtask

   initial begin
      idle_inputs();

      // Reset with a busy ID stage: everything must stay at zero
      rand_inputs();
      d_valid = 1; flush = 0;
      repeat (3) @(posedge clock);
      #1;
      mdl = '0; mdl_cnt = 0;
      check_val("reset_stall", 32'(stall), 32'd0);
      compare_outputs();
      idle_inputs();
      #1 resetn = 1;

      // EX forwarding: add $3,$1,$2 then sub $4,$3,$5
      instr(5'd1, 5'd2, 5'd3, ALU_ADD, 1'b1, 1'b0);
      step();
      instr(5'd3, 5'd5, 5'd4, ALU_SUB, 1'b1, 1'b0);
      d_qa = 32'hDEAD; e_alu_s = 32'h1234;
      step();
      check_val("ex_fwd_a", e_a, 32'h1234);
      check_val("ex_fwd_aluc", 32'(e_aluc), 32'(4'b0100));

      // MEM forwarding of load data, then EX taking priority over MEM
      instr(5'd10, 5'd11, 5'd6, ALU_OR, 1'b1, 1'b0);
      step();
      instr(5'd7, 5'd12, 5'd7, ALU_ADD, 1'b1, 1'b0);
      m_wreg = 1; m_rn = 5'd7; m_m2reg = 1; m_mem = 32'h55; m_alu = 32'h99;
      step();
      check_val("mem_fwd_a", e_a, 32'h55);
      instr(5'd7, 5'd12, 5'd13, ALU_ADD, 1'b1, 1'b0);
      e_alu_s = 32'h66;
      step();
      check_val("ex_over_mem_a", e_a, 32'h66);
      idle_inputs();

      // Load-use: lw $8 then add $9,$8,$1 from a clean counter
      do_reset();
      instr(5'd1, 5'd0, 5'd8, ALU_ADD, 1'b0, 1'b1);
      step();
      instr(5'd8, 5'd1, 5'd9, ALU_ADD, 1'b1, 1'b0);
      d_qa = 32'hBAD;
      #1 check_val("lu_stall_hi", 32'(stall), 32'd1);
      step();
      check_val("lu_bubble_valid", 32'(e_valid), 32'd0);
      check_val("lu_bubble_cnt", 32'(bubble_cnt), 32'd1);
      m_wreg = 1; m_rn = 5'd8; m_m2reg = 1; m_mem = 32'hAB;
      #1 check_val("lu_stall_lo", 32'(stall), 32'd0);
      step();
      check_val("lu_retry_a", e_a, 32'hAB);
      idle_inputs();

      // Shift amount and immediate operand selection
      instr(5'd0, 5'd3, 5'd2, ALU_SLL, 1'b1, 1'b0);
      d_shift = 1; d_imm = 32'd5 << 6; d_qb = 32'hF;
      step();
      check_val("sll_a", e_a, 32'd5);
      check_val("sll_b", e_b, 32'hF);
      check_val("sll_aluc", 32'(e_aluc), 32'(4'b0011));
      instr(5'd4, 5'd5, 5'd5, ALU_ADD, 1'b0, 1'b0);
      d_aluimm = 1; d_imm = 32'hFFFF_FFFF;
      step();
      check_val("addi_b", e_b, 32'hFFFF_FFFF);

      // Flush together with a load-use hazard
      do_reset();
      instr(5'd1, 5'd0, 5'd8, ALU_ADD, 1'b0, 1'b1);
      step();
      instr(5'd8, 5'd1, 5'd9, ALU_ADD, 1'b1, 1'b0);
      flush = 1;
      step();
      check_val("fh_valid", 32'(e_valid), 32'd0);
      check_val("fh_cnt", 32'(bubble_cnt), 32'd1);
      idle_inputs();

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         rand_inputs();
         step();
      end

      // Counter saturation: 2^16+3 flush bubbles
      do_reset();
      idle_inputs();
      d_valid = 1; flush = 1;
      repeat ((1 << BCNT_W) + 3) @(posedge clock);
      #1;
      check_val("sat_cnt", 32'(bubble_cnt), 32'h0000_FFFF);
      check_val("sat_valid", 32'(e_valid), 32'd0);
      mdl = '0; mdl_cnt = CNT_MAX;
      step();
      flush = 0;
      instr(5'd1, 5'd2, 5'd3, ALU_XOR, 1'b1, 1'b0);
      d_pc4 = 32'h0040_0010;
      step();

      // Asynchronous reset in the middle of a cycle
      #2 resetn = 0;
      #1;
      mdl = '0; mdl_cnt = 0;
      check_val("async_rst_stall", 32'(stall), 32'd0);
      compare_outputs();

      // First edge after reset release captures ID normally
      #1 resetn = 1;
      instr(5'd2, 5'd3, 5'd4, ALU_AND, 1'b1, 1'b0);
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/id_exe_stage.md
# id_exe_stage

ID/EXE stage of the five-stage MIPS pipeline, directly upstream of the ALU. Each cycle it resolves operand forwarding from the EX and MEM stages, detects load-use hazards, and registers the selected ALU operands `a` and `b`, `aluc`, and the downstream control bits. On a load-use hazard or a branch flush it inserts a bubble. It also counts bubbles for performance debug.

## Interface
- `BCNT_W`, 16: bubble counter width.
- `clock` in 1: pipeline clock, rising edge.
- `resetn` in 1: asynchronous reset, active low.
- `d_valid` in 1: an instruction is present in ID.
- `d_rs`, `d_rt`, `d_rn` in 5 each: source registers and destination register (already 31 for `jal`).
- `d_qa`, `d_qb` in 32 each: register-file read data.
- `d_imm` in 32: extended immediate. Bits [10:6] hold the shift amount `sa`.
- `d_aluc` in 4: ALU operation code.
- Control bits, in 1 each: `d_aluimm`, `d_shift`, `d_wreg`, `d_m2reg`, `d_wmem`, `d_jal`, `d_usert`. `d_usert` means `rt` is a true source (R-type or store).
- `d_pc4` in 32: PC+4.
- `e_alu_s` in 32: current ALU result in EX, combinational.
- `m_wreg`, `m_m2reg` in 1 each; `m_rn` in 5: MEM-stage destination information.
- `m_alu`, `m_mem` in 32 each: MEM-stage ALU result and load data.
- `flush` in 1: kill the instruction currently in ID (branch or jump taken).
- `stall` out 1: hold PC and IF/ID.
- `e_a`, `e_b` out 32 each: ALU operands.
- `e_aluc` out 4: ALU operation code.
- `e_wreg`, `e_m2reg`, `e_wmem`, `e_jal`, `e_valid` out 1 each.
- `e_rn` out 5; `e_pc4` out 32; `e_st` out 32 (forwarded `rt` value, used as store data).
- `bubble_cnt` out `BCNT_W`: saturating bubble count.

## Operation
- **Forwarding for source `r`** (`rs`, or `rt` only when `d_usert`):
  - Condition: `r != 0`.
  - Priority 1: EX. If the registered `e_valid & e_wreg & ~e_m2reg & e_rn == r`, take `e_alu_s`.
  - Priority 2: MEM. Else if `m_wreg & m_rn == r`, take `m_m2reg ? m_mem : m_alu`.
  - Otherwise take `d_qa` / `d_qb`.
- **Load-use hazard**: `d_valid & e_valid & e_wreg & e_m2reg & e_rn != 0`, and `e_rn` equals `d_rs`, or equals `d_rt` with `d_usert`.
  - `stall = hazard & ~flush`.
- **Operand select**:
  - `a = d_shift ? {27'b0, d_imm[10:6]} : fwd_rs`
  - `b = d_aluimm ? d_imm : fwd_rt`
  - `st = fwd_rt`
- **Register update**, every rising edge:
  - If `flush | hazard | ~d_valid`, load a bubble: `e_valid`, `e_wreg`, `e_m2reg`, `e_wmem` and `e_jal` are 0. `e_a`, `e_b`, `e_st`, `e_aluc` and `e_rn` are 0. `e_pc4` is 0.
  - Otherwise capture the selected values and the `d_*` control bits, with `e_valid = 1`.
- **Bubble counter**:
  - Increments on every edge where `d_valid & (hazard | flush)`.
  - Saturates at all ones and never wraps.
- **No internal FSM.** State is the EX register set plus `bubble_cnt`.

## Timing
- **Reset**: all outputs are 0 while `resetn` is low. This applies immediately and asynchronously.
  - `stall` is 0 after reset because `e_valid` = 0.
- **Latency**: operands are presented on `e_*` one cycle after ID.
- **`stall`** is combinational from the `d_*` inputs and the registered `e_*` state, and is valid within the same cycle.
  - It lasts exactly one cycle per load-use hazard: the bubble clears `e_valid`, so the hazard drops on the next cycle.
  - The retried instruction then gets the load data via the MEM forwarding path.
- **Simultaneous `flush` and `hazard`**: a bubble is inserted, `stall` = 0, and the counter increments by 1 only.
- **Register 0**: a destination of 0 never forwards and never triggers a stall.
- **Reset deasserted mid-stream**: the first edge captures ID normally. There is no pending hazard state.

## Structure
- **Shared package `mips_pkg`**:
  - ALU codes `ALU_ADD = 4'b0000`, `ALU_SUB = 4'b0100`, `ALU_AND = 4'b0001`, `ALU_OR = 4'b0101`, `ALU_XOR = 4'b0010`, `ALU_LUI = 4'b0110`, `ALU_SLL = 4'b0011`, `ALU_SRL = 4'b0111`, `ALU_SRA = 4'b1111`.
  - `REG_ZERO = 5'd0`, `REG_RA = 5'd31`.
- **Sub-module `fwd_unit`**: a combinational per-operand forwarding mux, instantiated twice (`rs`, `rt`).
  - Hazard detection, operand muxes, the EX register and the counter live in `id_exe_stage`.

## Test plan
- **Reset**: hold `resetn` = 0 with active `d_*` inputs → all `e_*` are 0, `stall` = 0, `bubble_cnt` = 0.
- **EX forwarding**:
  - Cycle 1: `add $3,$1,$2`, giving `e_rn` = 3.
  - Cycle 2: `sub $4,$3,$5` with `d_qa` = 0xDEAD and `e_alu_s` = 0x1234.
  - Expect `e_a` = 0x1234 next cycle and `e_aluc` = 4'b0100.
- **MEM priority**: `m_rn` = 7, `m_m2reg` = 1, `m_mem` = 0x55, and EX not writing `$7`. Read `$7` → `e_a` = 0x55. If EX also writes `$7` with `e_alu_s` = 0x66 → `e_a` = 0x66.
- **Load-use**:
  - `lw $8` is in EX; ID holds `add $9,$8,$1`.
  - Expect `stall` = 1 for exactly one cycle, a bubble with `e_valid` = 0, and `bubble_cnt` = 1.
  - Next cycle, with `m_mem` = 0xAB → `e_a` = 0xAB.
- **Shift and immediate**: `sll $2,$3,5` with `d_imm[10:6]` = 5 and `$3` = 0xF → `e_a` = 5, `e_b` = 0xF, `e_aluc` = 4'b0011. `addi` with `d_imm` = 0xFFFFFFFF → `e_b` = 0xFFFFFFFF.
- **Flush + hazard, saturation**:
  - `flush` = 1 during a load-use case → `stall` = 0, a bubble, and the counter increments by 1.
  - Force 2^16+3 bubble events → `bubble_cnt` = 0xFFFF.
